chunked_adder_carry: RTL

- Multi-cycle signed adder with carry-in/carry-out; the additive counterpart of the team's ripple subtractor-with-carry datapath.
- Adds CHUNK bits per clock through one shared CHUNK-bit adder slice to save area; intended for the mini-micro ALU's multi-cycle arithmetic path.
- Operand capture and result delivery use valid/ready handshakes.

---
 rtl/chunked_adder_carry.sv | 132 +++++++++++++
 1 files changed

// File: rtl/chunked_adder_carry.sv
// Multi-cycle adder: num1 + num2 + c_in, CHUNK bits per clock through one shared adder slice.
// Optional overflow/zero/negative flags when CHUNKED_ADDER_FLAGS_EN is defined.
module chunked_adder_carry #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             c_in,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             busy
`ifdef CHUNKED_ADDER_FLAGS_EN
    ,
    output logic             overflow,
    output logic             zero,
    output logic             negative
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, acc_q, acc_nxt, result_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q, c_out_q;
    logic [CHUNK:0]    sum;

    // The single shared slice: current chunk of A and B plus the running carry.
    always_comb begin
        sum = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, carry_q};
        acc_nxt = acc_q;
        acc_nxt[idx_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (idx_q == LAST) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // acc_q collects chunks; result_q only moves on the final chunk so the
    // visible result never shows partial sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            c_out_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid && in_ready) begin
                    a_q     <= num1;
                    b_q     <= num2;
                    carry_q <= c_in;
                    idx_q   <= '0;
                    acc_q   <= '0;
                end
                ADD: begin
                    acc_q   <= acc_nxt;
                    carry_q <= sum[CHUNK];
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        result_q <= acc_nxt;
                        c_out_q  <= sum[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign c_out  = c_out_q;

`ifdef CHUNKED_ADDER_FLAGS_EN
    logic ovf_q, zero_q, neg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (state_q == ADD && idx_q == LAST) begin
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
            zero_q <= (acc_nxt == '0);
            neg_q  <= acc_nxt[WIDTH-1];
        end
    end

    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign negative = neg_q;
`endif

endmodule
